// File: rtl/mag_cmp_seq.sv
// Digit-serial magnitude comparator: compares a and b DW bits per clock, MSB digit
// first, stopping at the first differing digit. Optional two's-complement mode.
module mag_cmp_seq #(
   parameter int W  = 16,
   parameter int DW = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         signed_mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         ready,
   output logic         done_tick,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   // state | meaning
   // IDLE  | waiting for start, ready=1, results held
   // RUN   | comparing one digit pair per edge
   // DONE  | result valid, done_tick=1 for this cycle

   localparam int ND = W / DW;
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;

   generate
      if ((W % DW) != 0) begin : g_bad_width
         $error("mag_cmp_seq: W must be an integer multiple of DW");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [CW-1:0]   r_cnt;
   logic            r_gt;
   logic            r_eq;
   logic            r_lt;
   logic [W-1:0]    w_flip;
   logic [DW-1:0]   w_da;
   logic [DW-1:0]   w_db;
   logic            w_last;

   // Inverting both MSBs maps two's complement onto offset binary, so the
   // same unsigned digit compare serves both modes.
   always_comb begin
      w_flip        = '0;
      w_flip[W-1]   = signed_mode;
   end

   // Operands are shifted left each step, so the current digit is always on top.
   assign w_da   = r_a[W-1 -: DW];
   assign w_db   = r_b[W-1 -: DW];
   assign w_last = (r_cnt == CW'(ND - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if ((w_da != w_db) || w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_gt  <= 1'b0;
         r_eq  <= 1'b0;
         r_lt  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= a ^ w_flip;
                  r_b   <= b ^ w_flip;
                  r_cnt <= '0;
                  r_gt  <= 1'b0;
                  r_eq  <= 1'b0;
                  r_lt  <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_da > w_db) begin
                  r_gt <= 1'b1;
               end else if (w_da < w_db) begin
                  r_lt <= 1'b1;
               end else if (w_last) begin
                  r_eq <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  r_a   <= r_a << DW;
                  r_b   <= r_b << DW;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready     = (r_state == S_IDLE);
   assign done_tick = (r_state == S_DONE);
   assign gt        = r_gt;
   assign eq        = r_eq;
   assign lt        = r_lt;

endmodule
